// File: rtl/masking_share_gen.sv
// Splits each plaintext bit pair into two Boolean shares and emits a fresh remask bit.
// Randomness comes from a reseedable 32-bit Fibonacci LFSR that only advances while warming up or on an accept.
module masking_share_gen #(
  parameter logic [31:0] SEED   = 32'hACE1_2468,
  parameter int unsigned WARMUP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_a,
  input  logic        i_b,
  input  logic        i_reseed,
  input  logic [31:0] i_seed,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_a0,
  output logic        o_a1,
  output logic        o_b0,
  output logic        o_b1,
  output logic        o_rN,
  output logic        o_busy
);

  localparam int CW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

  typedef enum logic {WARM, RUN} state_t;

  generate
    if (SEED == 32'd0) begin : g_bad_seed
      $error("masking_share_gen: SEED must be non-zero");
    end
  endgenerate

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   lfsr_reg, lfsr_next;
  logic          valid_reg, valid_next;
  // Packed as {rN, b1, b0, a1, a0}
  logic [4:0]    share_reg, share_next;

  logic [31:0] step1;
  logic [31:0] step3;
  logic        accept;

  assign step1 = lfsr_step(lfsr_reg);
  assign step3 = lfsr_step(lfsr_step(step1));

  // A reseed cycle never consumes the offered word, so it is not advertised as ready.
  assign o_ready = (state_reg == RUN) && (~valid_reg || i_ready) && ~i_reseed;
  assign accept  = o_ready && i_valid;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lfsr_next  = lfsr_reg;
    valid_next = valid_reg;
    share_next = share_reg;
    if (i_reseed) begin
      lfsr_next  = (i_seed == 32'd0) ? SEED : i_seed;
      valid_next = 1'b0;
      cnt_next   = CW'(WARMUP);
      state_next = WARM;
    end else begin
      case (state_reg)
        WARM: begin
          if (cnt_reg == '0) begin
            state_next = RUN;
          end else begin
            lfsr_next = step1;
            cnt_next  = cnt_reg - CW'(1);
            // Leave on the last warm-up step so busy lasts exactly WARMUP cycles.
            if (cnt_reg == CW'(1)) begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            share_next = {lfsr_reg[2], i_b ^ lfsr_reg[1], lfsr_reg[1], i_a ^ lfsr_reg[0], lfsr_reg[0]};
            valid_next = 1'b1;
            lfsr_next  = step3;
          end else if (valid_reg && i_ready) begin
            valid_next = 1'b0;
          end
        end
        default: state_next = WARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WARM;
      cnt_reg   <= CW'(WARMUP);
      lfsr_reg  <= SEED;
      valid_reg <= 1'b0;
      share_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lfsr_reg  <= lfsr_next;
      valid_reg <= valid_next;
      share_reg <= share_next;
    end
  end

  assign o_valid = valid_reg;
  assign o_a0    = share_reg[0];
  assign o_a1    = share_reg[1];
  assign o_b0    = share_reg[2];
  assign o_b1    = share_reg[3];
  assign o_rN    = share_reg[4];
  assign o_busy  = (state_reg == WARM);

endmodule

// File: tb/tb_masking_share_gen.sv
// Randomized bench for masking_share_gen against a transaction-level model
// (LFSR value, warm-up budget, pending beat and a plaintext scoreboard queue).
module tb_masking_share_gen;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int          W    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_a, i_b, i_reseed, i_ready;
  logic [31:0] i_seed;
  logic        o_ready, o_valid, o_a0, o_a1, o_b0, o_b1, o_rN, o_busy;

  logic        z_valid, z_a, z_b, z_reseed, z_ready;
  logic [31:0] z_seed;
  logic        z_oready, z_ovalid, z_a0, z_a1, z_b0, z_b1, z_rN, z_busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  masking_share_gen u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_a(i_a), .i_b(i_b),
    .i_reseed(i_reseed), .i_seed(i_seed), .o_valid(o_valid), .i_ready(i_ready),
    .o_a0(o_a0), .o_a1(o_a1), .o_b0(o_b0), .o_b1(o_b1), .o_rN(o_rN), .o_busy(o_busy)
  );

  masking_share_gen #(.WARMUP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(z_valid), .o_ready(z_oready), .i_a(z_a), .i_b(z_b),
    .i_reseed(z_reseed), .i_seed(z_seed), .o_valid(z_ovalid), .i_ready(z_ready),
    .o_a0(z_a0), .o_a1(z_a1), .o_b0(z_b0), .o_b1(z_b1), .o_rN(z_rN), .o_busy(z_busy)
  );

  // Reference model state
  logic [31:0] m_lfsr;
  logic [4:0]  m_sh;
  bit          m_valid;
  int          m_warm, m_steps, m_acc;
  logic [1:0]  sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED;
    m_sh    = '0;
    m_valid = 0;
    m_warm  = (W > 0) ? W : 1;
    m_steps = W;
    sb.delete();
  endtask

  task automatic model_edge(input bit v, input bit a, input bit b, input bit rdy,
                            input bit rs, input logic [31:0] sd);
    logic [2:0] r;
    logic [1:0] done;
    if (rs) begin
      m_lfsr  = (sd == 32'd0) ? SEED : sd;
      m_valid = 0;
      m_warm  = (W > 0) ? W : 1;
      m_steps = W;
      sb.delete();
    end else if (m_warm > 0) begin
      if (m_steps > 0) begin
        m_lfsr = ref_step(m_lfsr);
        m_steps--;
      end
      m_warm--;
    end else begin
      bit acc;
      acc = v && (!m_valid || rdy);
      if (m_valid && rdy && sb.size() > 0) begin
        done = sb.pop_front();
        $display("beat done a=%0b b=%0b", done[1], done[0]);
      end
      if (acc) begin
        r       = m_lfsr[2:0];
        m_sh    = {r[2], b ^ r[1], r[1], a ^ r[0], r[0]};
        m_valid = 1;
        sb.push_back({a, b});
        m_lfsr  = ref_step(ref_step(ref_step(m_lfsr)));
        m_acc++;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  // One clock of the main DUT: drive, check ready, clock, check registered outputs.
  task automatic drive_cycle(input bit v, input bit a, input bit b, input bit rdy,
                             input bit rs, input logic [31:0] sd);
    bit exp_rdy;
    i_valid = v; i_a = a; i_b = b; i_ready = rdy; i_reseed = rs; i_seed = sd;
    #1;
    exp_rdy = (m_warm == 0) && (!m_valid || rdy) && !rs;
    check_eq("o_ready", 32'(o_ready), 32'(exp_rdy));
    @(posedge clk);
    model_edge(v, a, b, rdy, rs, sd);
    #1;
    check_eq("o_valid", 32'(o_valid), 32'(m_valid));
    check_eq("o_busy", 32'(o_busy), 32'(m_warm > 0));
    check_eq("shares", 32'({o_rN, o_b1, o_b0, o_a1, o_a0}), 32'(m_sh));
    check_eq("lfsr", u_dut.lfsr_reg, m_lfsr);
    if (m_valid && sb.size() > 0) begin
      check_eq("a_xor", 32'(o_a0 ^ o_a1), 32'(sb[0][1]));
      check_eq("b_xor", 32'(o_b0 ^ o_b1), 32'(sb[0][0]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int base;
    int cyc;
    i_valid = 0; i_a = 0; i_b = 0; i_reseed = 0; i_ready = 0; i_seed = '0;
    z_valid = 0; z_a = 0; z_b = 0; z_reseed = 0; z_ready = 1; z_seed = '0;
    m_acc = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd1);
    check_eq("rst_ready", 32'(o_ready), 32'd0);
    check_eq("rst_shares", 32'({o_rN, o_b1, o_b0, o_a1, o_a0}), 32'd0);
    check_eq("rst_lfsr", u_dut.lfsr_reg, SEED);
    rst_n = 1;

    // Warm-up length on the default instance; WARMUP=0 instance exercised alongside.
    busy_cnt = o_busy ? 1 : 0;
    z_reseed = 1; z_seed = 32'h5;
    drive_cycle(0, 0, 0, 0, 0, 0);
    busy_cnt += o_busy ? 1 : 0;
    z_reseed = 0; z_seed = '0;
    check_eq("z_lfsr_seed", u_dut0.lfsr_reg, 32'h5);
    drive_cycle(0, 0, 0, 0, 0, 0);
    busy_cnt += o_busy ? 1 : 0;
    check_eq("z_ready", 32'(z_oready), 32'd1);
    z_valid = 1; z_a = 1; z_b = 1;
    drive_cycle(0, 0, 0, 0, 0, 0);
    busy_cnt += o_busy ? 1 : 0;
    z_valid = 0; z_a = 0; z_b = 0;
    check_eq("z_valid", 32'(z_ovalid), 32'd1);
    check_eq("z_shares", 32'({z_rN, z_b1, z_b0, z_a1, z_a0}), 32'b11001);
    for (int k = 0; k < 9; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      busy_cnt += o_busy ? 1 : 0;
    end
    check_eq("warm_cycles", 32'(busy_cnt), 32'(W));

    // Back-to-back beats, no downstream stalls.
    for (int k = 0; k < 20; k++)
      drive_cycle(1, 1'($urandom), 1'($urandom), 1, 0, 0);

    // Random beats with random stalls.
    base = m_acc;
    cyc = 0;
    while (m_acc - base < 1000 && cyc < 10000) begin
      drive_cycle($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 6, 0, 0);
      cyc++;
    end
    check_eq("beats", 32'(m_acc - base), 32'd1000);
    drive_cycle(0, 0, 0, 1, 0, 0);

    // Reseed with zero seed while a beat is pending and another is offered.
    drive_cycle(1, 1, 0, 0, 0, 0);
    drive_cycle(1, 0, 1, 0, 1, 32'd0);
    check_eq("reseed_lfsr", u_dut.lfsr_reg, SEED);
    busy_cnt = o_busy ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      drive_cycle(0, 0, 0, 1, 0, 0);
      busy_cnt += o_busy ? 1 : 0;
    end
    check_eq("reseed_warm", 32'(busy_cnt), 32'(W));

    // Asynchronous reset in the middle of a stall.
    drive_cycle(1, 1, 0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    check_eq("stall_valid", 32'(o_valid), 32'd1);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_eq("arst_valid", 32'(o_valid), 32'd0);
    check_eq("arst_shares", 32'({o_rN, o_b1, o_b0, o_a1, o_a0}), 32'd0);
    check_eq("arst_busy", 32'(o_busy), 32'd1);
    check_eq("arst_lfsr", u_dut.lfsr_reg, SEED);
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 12; k++)
      drive_cycle(1, 1'($urandom), 1'($urandom), 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
